yp_sync_fifo_ex: RTL and testbench

Parametrised single-clock FIFO, next generation of the team's synchronous FIFO. Adds selectable read mode (registered or first-word-fall-through), programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. Drop-in buffer between producer/consumer stages in the same clock domain.

---
 rtl/yp_sync_fifo_ex_if.sv | 21 ++
 rtl/yp_sync_fifo_ex.sv | 73 +++++++
 tb/tb_yp_sync_fifo_ex.sv | 137 +++++++++++++
 3 files changed

// File: rtl/yp_sync_fifo_ex_if.sv
// yp_sync_fifo_ex_if: producer/consumer request and status bundle for yp_sync_fifo_ex
interface yp_sync_fifo_ex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic i_clr, i_wr_en, i_rd_en;
  logic [DATA_WIDTH-1:0] i_data_in, o_data_out;
  logic o_valid, o_full, o_empty, o_almost_full, o_almost_empty, o_overflow, o_underflow;
  logic [CW-1:0] o_count;
  modport master (
    output i_clr, i_wr_en, i_rd_en, i_data_in,
    input o_data_out, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
    input o_count, o_overflow, o_underflow
  );
  modport slave (
    input i_clr, i_wr_en, i_rd_en, i_data_in,
    output o_data_out, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
    output o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/yp_sync_fifo_ex.sv
// yp_sync_fifo_ex: single-clock FIFO with registered/FWFT read, thresholds, count, sticky errors and flush
module yp_sync_fifo_ex #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter bit FWFT       = 0,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input logic i_clk,
  input logic i_rstn,
  yp_sync_fifo_ex_if.slave fifo
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic empty, full, rd_acc, wr_acc, ovf, udf;
  // occupancy comes from the pointer difference; the extra wrap bit separates full from empty
  assign count = wr_ptr - rd_ptr;
  assign empty = count == '0;
  assign full = count == PW'(FIFO_DEPTH);
  assign rd_acc = fifo.i_rd_en & ~empty;
  assign wr_acc = fifo.i_wr_en & (~full | rd_acc);
  assign fifo.o_empty = empty;
  assign fifo.o_full = full;
  assign fifo.o_count = count;
  assign fifo.o_almost_full = count >= PW'(AF_THRESH);
  assign fifo.o_almost_empty = count <= PW'(AE_THRESH);
  assign fifo.o_overflow = ovf;
  assign fifo.o_underflow = udf;
  // pointers and sticky error flags; flush wins over any same-cycle request
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (fifo.i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_acc);
      rd_ptr <= rd_ptr + PW'(rd_acc);
      ovf <= ovf | (fifo.i_wr_en & ~wr_acc);
      udf <= udf | (fifo.i_rd_en & empty);
    end
  // storage is never reset; a write during flush lands in a slot the reset pointers treat as free
  always_ff @(posedge i_clk)
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= fifo.i_data_in;
  if (FWFT) begin : g_fwft
    assign fifo.o_data_out = mem[rd_ptr[AW-1:0]];
    assign fifo.o_valid = ~empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] data_q;
    logic valid_q;
    assign fifo.o_data_out = data_q;
    assign fifo.o_valid = valid_q;
    // registered read port: data holds its last value between accepted reads
    always_ff @(posedge i_clk or negedge i_rstn)
      if (!i_rstn) begin
        data_q <= '0;
        valid_q <= 1'b0;
      end else if (fifo.i_clr) begin
        data_q <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) data_q <= mem[rd_ptr[AW-1:0]];
      end
  end
endmodule

// File: tb/tb_yp_sync_fifo_ex.sv
// tb_yp_sync_fifo_ex: directed and random checks of registered and FWFT FIFOs against a queue model
module tb_yp_sync_fifo_ex;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  logic [7:0] ed = 8'h00;
  logic ev = 1'b0, ov = 1'b0, uf = 1'b0, ra, wa;
  yp_sync_fifo_ex_if #(.DATA_WIDTH(8), .FIFO_DEPTH(32)) b0 ();
  yp_sync_fifo_ex_if #(.DATA_WIDTH(8), .FIFO_DEPTH(32)) b1 ();
  yp_sync_fifo_ex #(.DATA_WIDTH(8), .FIFO_DEPTH(32), .FWFT(0)) dut0 (.i_clk(clk), .i_rstn(rstn), .fifo(b0.slave));
  yp_sync_fifo_ex #(.DATA_WIDTH(8), .FIFO_DEPTH(32), .FWFT(1)) dut1 (.i_clk(clk), .i_rstn(rstn), .fifo(b1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic drive(input logic c, input logic w, input logic [7:0] d, input logic r);
    b0.i_clr = c; b0.i_wr_en = w; b0.i_data_in = d; b0.i_rd_en = r;
    b1.i_clr = c; b1.i_wr_en = w; b1.i_data_in = d; b1.i_rd_en = r;
  endtask
  task automatic cyc(input logic c, input logic w, input logic [7:0] d, input logic r);
    drive(c, w, d, r);
    @(negedge clk);
  endtask
  // reference: a plain queue of accepted words plus sticky flags, both DUTs get identical stimulus
  always @(posedge clk or negedge rstn) begin
    if (!rstn || b0.i_clr) begin
      q.delete();
      ed = 8'h00; ev = 1'b0; ov = 1'b0; uf = 1'b0;
    end else begin
      ra = b0.i_rd_en && q.size() > 0;
      wa = b0.i_wr_en && (q.size() < 32 || ra);
      ov = ov | (b0.i_wr_en && !wa);
      uf = uf | (b0.i_rd_en && q.size() == 0);
      ev = ra;
      if (ra) ed = q.pop_front();
      if (wa) q.push_back(b0.i_data_in);
    end
  end
  // every-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    chk("count0", 32'(b0.o_count), q.size());
    chk("count1", 32'(b1.o_count), q.size());
    chk("empty0", 32'(b0.o_empty), 32'(q.size() == 0));
    chk("full0", 32'(b0.o_full), 32'(q.size() == 32));
    chk("afull0", 32'(b0.o_almost_full), 32'(q.size() >= 30));
    chk("aempty0", 32'(b0.o_almost_empty), 32'(q.size() <= 2));
    chk("ovf0", 32'(b0.o_overflow), 32'(ov));
    chk("udf0", 32'(b0.o_underflow), 32'(uf));
    chk("ovf1", 32'(b1.o_overflow), 32'(ov));
    chk("udf1", 32'(b1.o_underflow), 32'(uf));
    chk("full1", 32'(b1.o_full), 32'(q.size() == 32));
    chk("data0", 32'(b0.o_data_out), 32'(ed));
    chk("valid0", 32'(b0.o_valid), 32'(ev));
    chk("valid1", 32'(b1.o_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("data1", 32'(b1.o_data_out), 32'(q[0]));
  end
  initial begin
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(b0.o_count), 0);
    chk("rst_empty", 32'(b0.o_empty), 1);
    chk("rst_aempty", 32'(b0.o_almost_empty), 1);
    chk("rst_valid", 32'(b0.o_valid), 0);
    rstn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 8'(i), 0);
      if (i == 1) chk("ae_at2", 32'(b0.o_almost_empty), 1);
      if (i == 2) chk("ae_at3", 32'(b0.o_almost_empty), 0);
      if (i == 28) chk("af_at29", 32'(b0.o_almost_full), 0);
      if (i == 29) chk("af_at30", 32'(b0.o_almost_full), 1);
    end
    chk("full_at32", 32'(b0.o_full), 1);
    cyc(0, 1, 8'hEE, 0);
    chk("ovf_set", 32'(b0.o_overflow), 1);
    chk("ovf_count", 32'(b0.o_count), 32);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 1);
      chk("drain_data", 32'(b0.o_data_out), i);
      chk("drain_valid", 32'(b0.o_valid), 1);
    end
    cyc(0, 0, 0, 1);
    chk("udf_set", 32'(b0.o_underflow), 1);
    chk("udf_valid", 32'(b0.o_valid), 0);
    chk("udf_hold", 32'(b0.o_data_out), 32'h1F);
    cyc(1, 0, 0, 0);
    chk("clr_ovf", 32'(b0.o_overflow), 0);
    for (int i = 0; i < 32; i++) cyc(0, 1, 8'(8'h40 + i), 0);
    cyc(0, 1, 8'hAA, 1);
    chk("fullrw_data", 32'(b0.o_data_out), 32'h40);
    chk("fullrw_count", 32'(b0.o_count), 32);
    chk("fullrw_ovf", 32'(b0.o_overflow), 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 1);
    chk("fullrw_last", 32'(b0.o_data_out), 32'hAA);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 8'h55, 0);
    chk("fwft_valid", 32'(b1.o_valid), 1);
    chk("fwft_first", 32'(b1.o_data_out), 32'h55);
    cyc(0, 1, 8'h66, 1);
    chk("fwft_next", 32'(b1.o_data_out), 32'h66);
    chk("fwft_count", 32'(b1.o_count), 1);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      cyc(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 33; i++) cyc(0, 1, 8'(8'h80 + i), 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1);
    chk("pre_clr_count", 32'(b0.o_count), 17);
    chk("pre_clr_ovf", 32'(b0.o_overflow), 1);
    cyc(1, 1, 8'h77, 1);
    chk("clr_count", 32'(b0.o_count), 0);
    chk("clr_empty", 32'(b0.o_empty), 1);
    chk("clr_ovf2", 32'(b0.o_overflow), 0);
    chk("clr_data", 32'(b0.o_data_out), 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'hC0 + i), i == 4);
    drive(0, 1, 8'hD0, 1);
    #7;
    rstn = 1'b0;
    #1;
    chk("arst_count", 32'(b0.o_count), 0);
    chk("arst_empty", 32'(b0.o_empty), 1);
    chk("arst_data", 32'(b0.o_data_out), 0);
    chk("arst_valid", 32'(b0.o_valid), 0);
    chk("arst_valid1", 32'(b1.o_valid), 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    rstn = 1'b1;
    cyc(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
